// File: rtl/ttfir_pkg.sv
// Shared defaults and the output clipping helper for the TinyTapeout FIR decimator chain.
package ttfir_pkg;

  localparam int unsigned BW_IN_DEF      = 8;
  localparam int unsigned BW_OUT_DEF     = 6;
  localparam int unsigned LOG2_M_MAX_DEF = 3;

  // Clip a signed value into the signed range of a bw-bit word. The result keeps all 32 bits,
  // so the caller can detect clipping by comparing against the input.
  function automatic logic signed [31:0] sat_clip(input logic signed [31:0] v,
                                                   input int unsigned       bw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (bw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bw - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/ttfir_fifo2.sv
// Two-entry ready/valid queue. A push while full is only accepted if a pop frees a slot on the
// same edge; otherwise the new word is discarded and o_wr_full_drop pulses.
module ttfir_fifo2
  import ttfir_pkg::*;
#(
  parameter int unsigned Width = BW_OUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_valid,
  output logic             o_wr_full_drop
);

  logic [Width-1:0] r_mem [2];
  logic             r_head;
  logic [1:0]       r_count;

  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_tail;

  // Handshake decode; tail slot equals head when full, which is the slot a same-edge pop frees.
  always_comb begin
    w_pop          = i_pop && (r_count != 2'd0);
    w_full         = (r_count == 2'd2);
    w_wr           = i_push && (!w_full || w_pop);
    o_wr_full_drop = i_push && w_full && !w_pop;
    w_tail         = r_head ^ r_count[0];
    o_valid        = (r_count != 2'd0);
    o_data         = o_valid ? r_mem[r_head] : '0;
  end

  // Storage, head pointer and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) begin
        r_mem[w_tail] <= i_data;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/ttfir_decimator.sv
// Integrate-and-dump decimator: averages blocks of 2^dec_sel samples, saturates the mean to
// BW_out bits and queues results in a two-entry ready/valid buffer.
module ttfir_decimator
  import ttfir_pkg::*;
#(
  parameter int unsigned BW_in      = BW_IN_DEF,
  parameter int unsigned BW_out     = BW_OUT_DEF,
  parameter int unsigned LOG2_M_MAX = LOG2_M_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BW_in-1:0]  x_in,
  input  logic              in_valid,
  input  logic [1:0]        dec_sel,
  output logic [BW_out-1:0] y_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sat_flag,
  output logic              drop_flag
);

  localparam int unsigned BW_acc = BW_in + LOG2_M_MAX;
  localparam int unsigned MSW    = $clog2(LOG2_M_MAX + 1);

  logic signed [BW_acc-1:0]     r_acc;
  logic        [LOG2_M_MAX-1:0] r_cnt;
  logic        [MSW-1:0]        r_m_sel;
  logic                         r_sat;
  logic                         r_drop;

  logic        [MSW-1:0]    w_dec_clamp;
  logic        [MSW-1:0]    w_m_eff;
  logic signed [BW_acc-1:0] w_x_ext;
  logic signed [BW_acc-1:0] w_sum;
  logic signed [BW_acc-1:0] w_mean;
  logic signed [31:0]       w_mean_ext;
  logic signed [31:0]       w_clip;
  logic        [BW_out-1:0] w_res;
  logic                     w_clipped;
  logic                     w_last;
  logic                     w_push;
  logic                     w_drop;

  // Block arithmetic; the exponent is re-sampled only at block start so mid-block dec_sel
  // changes wait for the next block.
  always_comb begin
    if (32'(dec_sel) > LOG2_M_MAX) begin
      w_dec_clamp = MSW'(LOG2_M_MAX);
    end else begin
      w_dec_clamp = MSW'(dec_sel);
    end
    w_m_eff    = (r_cnt == '0) ? w_dec_clamp : r_m_sel;
    w_x_ext    = {{LOG2_M_MAX{x_in[BW_in-1]}}, x_in};
    w_sum      = ((r_cnt == '0) ? '0 : r_acc) + w_x_ext;
    w_last     = ({{(32 - LOG2_M_MAX){1'b0}}, r_cnt} == ((32'd1 << w_m_eff) - 32'd1));
    w_mean     = w_sum >>> w_m_eff;
    w_mean_ext = {{(32 - BW_acc){w_mean[BW_acc-1]}}, w_mean};
    w_clip     = sat_clip(w_mean_ext, BW_out);
    w_res      = w_clip[BW_out-1:0];
    w_clipped  = (w_clip != w_mean_ext);
    w_push     = in_valid && w_last;
  end

  // Accumulator, sample counter, latched exponent and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_m_sel <= '0;
      r_sat   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (in_valid) begin
        if (r_cnt == '0) begin
          r_m_sel <= w_dec_clamp;
        end
        if (w_last) begin
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_push && w_clipped) begin
        r_sat <= 1'b1;
      end
      if (w_drop) begin
        r_drop <= 1'b1;
      end
    end
  end

  ttfir_fifo2 #(
    .Width (BW_out)
  ) u_fifo (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_push         (w_push),
    .i_data         (w_res),
    .i_pop          (out_ready),
    .o_data         (y_out),
    .o_valid        (out_valid),
    .o_wr_full_drop (w_drop)
  );

  assign sat_flag  = r_sat;
  assign drop_flag = r_drop;

endmodule

// File: tb/tb_ttfir_decimator.sv
// Self-checking bench for ttfir_decimator: a block-averaging reference model checked every
// cycle, plus literal expectations from hand-worked vectors.
module tb_ttfir_decimator;
  import ttfir_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x_in;
  logic       in_valid;
  logic [1:0] dec_sel;
  logic [5:0] y_out;
  logic       out_valid;
  logic       out_ready;
  logic       sat_flag;
  logic       drop_flag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ttfir_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .dec_sel   (dec_sel),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag),
    .drop_flag (drop_flag)
  );

  function automatic int s6(input logic [5:0] v);
    return int'($signed(v));
  endfunction

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: collect a block of 2^m samples, floor-average, clip, enqueue (cap 2).
  int mq[$];
  int m_sum, m_n, m_msel, m_res;
  bit m_sat, m_drop, m_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_sum = 0; m_n = 0; m_msel = 0; m_sat = 0; m_drop = 0;
    end else begin
      m_push = 0;
      m_res  = 0;
      if (in_valid) begin
        if (m_n == 0) begin
          m_msel = (int'(dec_sel) > int'(LOG2_M_MAX_DEF)) ? int'(LOG2_M_MAX_DEF) : int'(dec_sel);
          m_sum  = 0;
        end
        m_sum = m_sum + int'($signed(x_in));
        m_n++;
        if (m_n == (1 << m_msel)) begin
          m_res = floor_div(m_sum, 1 << m_msel);
          if (m_res > 31) begin
            m_res = 31; m_sat = 1;
          end else if (m_res < -32) begin
            m_res = -32; m_sat = 1;
          end
          m_push = 1;
          m_n    = 0;
        end
      end
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < 2) mq.push_back(m_res);
        else m_drop = 1;
      end
    end
  end

  // Per-cycle comparison against the model, and a log of values the DUT hands over.
  int pops[$];
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", int'(out_valid), int'(mq.size() != 0));
      check("y_out", s6(y_out), (mq.size() != 0) ? mq[0] : 0);
      check("sat_flag", int'(sat_flag), int'(m_sat));
      check("drop_flag", int'(drop_flag), int'(m_drop));
      if (out_valid && out_ready) pops.push_back(s6(y_out));
    end
  end

  task automatic send(input int v);
    in_valid = 1'b1;
    x_in     = 8'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x_in = '0; dec_sel = '0; out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    check("reset_valid", int'(out_valid), 0);
    check("reset_y", s6(y_out), 0);
    check("reset_sat", int'(sat_flag), 0);
    check("reset_drop", int'(drop_flag), 0);

    // Reset mid-block: the 10, 20 partial block must be forgotten.
    dec_sel = 2'd2;
    send(10); send(20);
    rst = 1'b1; #2; rst = 1'b0;
    repeat (4) send(8);
    check("rstblk_valid", int'(out_valid), 1);
    check("rstblk_y", s6(y_out), 8);
    check("rstblk_sat", int'(sat_flag), 0);
    check("rstblk_drop", int'(drop_flag), 0);
    idle(1);

    // Average with negative sum: -2 >>> 2 = -1, shown for exactly one cycle.
    send(3); send(5); send(-9); send(-1);
    check("avg_valid", int'(out_valid), 1);
    check("avg_y", s6(y_out), -1);
    idle(1);
    check("avg_gone", int'(out_valid), 0);

    // dec_sel change mid-block: first block still uses M=2.
    dec_sel = 2'd1;
    send(4);
    dec_sel = 2'd0;
    send(6);
    check("decchg_y0", s6(y_out), 5);
    send(9);
    check("decchg_y1", s6(y_out), 9);

    // Saturation at both ends of the 6-bit range.
    send(100);
    check("sat_hi_y", s6(y_out), 31);
    check("sat_hi_flag", int'(sat_flag), 1);
    send(-128);
    check("sat_lo_y", s6(y_out), -32);
    idle(2);
    check("sat_sticky", int'(sat_flag), 1);

    // Backpressure: third result dropped, then push+pop while full.
    out_ready = 1'b0;
    pops.delete();
    send(1); send(2); send(3);
    check("bp_drop", int'(drop_flag), 1);
    check("bp_head", s6(y_out), 1);
    out_ready = 1'b1;
    send(4);
    idle(2);
    check("bp_npops", pops.size(), 3);
    if (pops.size() == 3) begin
      check("bp_pop0", pops[0], 1);
      check("bp_pop1", pops[1], 2);
      check("bp_pop2", pops[2], 4);
    end
    check("bp_empty", int'(out_valid), 0);

    // Gapped input, M=8: gaps must not restart the block.
    dec_sel = 2'd3;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("gap_pending", int'(out_valid), 0);
      send(-5);
      if (i < 7) idle(3);
    end
    check("gap_valid", int'(out_valid), 1);
    check("gap_y", s6(y_out), -5);
    idle(2);

    // Mixed traffic, checked by the model only.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      x_in      = 8'($urandom);
      dec_sel   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
